// File: rtl/spin_ram_pkg.sv
// Shared types and helpers for the arbitrated spin/weight RAM.
// Holds the sweep/run state type, the round-robin pick and the index-width helper.
package spin_ram_pkg;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  localparam int MAX_CH = 8;

  // Width of a channel index; never below 1 so a single channel still has a usable vector.
  function automatic int clog2_min1(input int v);
    int w;
    w = 1;
    for (int i = 1; i < 16; i++) begin
      if ((1 << i) < v) w = i + 1;
    end
    return w;
  endfunction

  // One-hot grant: first requester found scanning upward from the channel after `last`.
  function automatic logic [MAX_CH-1:0] rr_grant(input logic [MAX_CH-1:0] req,
                                                 input int last, input int n);
    logic [MAX_CH-1:0] g;
    logic              found;
    int                c;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_CH; k++) begin
      c = (last + k) % n;
      if (k <= n && !found && req[c[2:0]]) begin
        g[c[2:0]] = 1'b1;
        found     = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/spin_ram_core.sv
// Single-port inferred RAM: synchronous write, registered read address.
// The array has no reset; contents are defined only by the clear sweep.
module spin_ram_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] raddr_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    raddr_q <= addr_i;
  end

  // Read-after-write to the same address sees the new word one grant later.
  assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/multiport_spin_ram.sv
// N-channel round-robin arbiter with clear sweep in front of one single-port RAM.
// gnt is combinational; read data returns one cycle after its grant.
import spin_ram_pkg::*;

module multiport_spin_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  input  logic                     clear,
  output logic                     busy,
  output logic                     clear_done
);

  localparam int IDX_W = clog2_min1(NUM_CH);
  localparam logic [ADDR_W-1:0] SA_LAST = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sa_q, sa_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [NUM_CH-1:0] rvalid_q, rvalid_d;

  logic [NUM_CH-1:0] gnt_rr, gnt_c;
  logic [IDX_W-1:0]  gnt_idx;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    last_d     = last_q;
    gnt_c      = '0;
    busy       = 1'b0;
    clear_done = 1'b0;
    gnt_rr     = NUM_CH'(rr_grant(MAX_CH'(req), int'(last_q), NUM_CH));

    if (state_q == CLEAR) begin
      busy = 1'b1;
      // sa wraps back to 0 on the last write, so RUN always starts the next sweep at 0.
      sa_d = sa_q + 1'b1;
      if (sa_q == SA_LAST) begin
        clear_done = 1'b1;
        state_d    = RUN;
      end
    end else if (clear) begin
      state_d = CLEAR;
    end else begin
      gnt_c = gnt_rr;
    end

    gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_c[i]) gnt_idx = IDX_W'(i);
    end
    if (|gnt_c) last_d = gnt_idx;

    if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = sa_q;
      ram_wdata = '0;
    end else begin
      ram_we    = |(gnt_c & we);
      ram_addr  = addr[gnt_idx*ADDR_W +: ADDR_W];
      ram_wdata = wdata[gnt_idx*DATA_W +: DATA_W];
    end

    rvalid_d = gnt_c & ~we;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= CLEAR;
      sa_q     <= '0;
      last_q   <= IDX_W'(NUM_CH - 1);
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
    end
  end

  spin_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign gnt    = gnt_c;
  assign rvalid = rvalid_q;
  assign rdata  = (|rvalid_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_multiport_spin_ram.sv
// Bench for multiport_spin_ram: directed vector table, clear/reset sequences,
// a random run against a behavioural model, and a 4-channel instance.
module tb_multiport_spin_ram;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear, busy, clear_done;
  logic [1:0]  req, we, gnt, rvalid;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic [7:0]  rdata;

  logic        reset4, clear4, busy4, cd4;
  logic [3:0]  req4, we4, gnt4, rvalid4;
  logic [15:0] addr4, rdata4;
  logic [63:0] wdata4;

  multiport_spin_ram dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .clear(clear), .busy(busy),
    .clear_done(clear_done)
  );

  multiport_spin_ram #(.DATA_W(16), .ADDR_W(4), .NUM_CH(4)) dut4 (
    .clk(clk), .reset(reset4), .req(req4), .we(we4), .addr(addr4), .wdata(wdata4),
    .gnt(gnt4), .rvalid(rvalid4), .rdata(rdata4), .clear(clear4), .busy(busy4),
    .clear_done(cd4)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0] req, we;
    logic [5:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] egnt, ervalid;
    logic [7:0] erdata;
  } vec_t;

  vec_t tbl [11];

  // Behavioural model: remaining sweep cycles, rr pointer, array image, pending read.
  int         m_sweep, m_last, m_pend;
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_pdata;
  logic [1:0] prev_gnt;

  task automatic sweep(input string nm, input int stop_at);
    for (int n = 1; n <= stop_at; n++) begin
      @(negedge clk);
      chk({nm, " busy"}, busy, 1'b1);
      chk({nm, " gnt"}, gnt, 2'b00);
      chk({nm, " clear_done"}, clear_done, (n == DEPTH));
      @(posedge clk); #1;
    end
  endtask

  task automatic model_step();
    logic [1:0] eg, erv;
    int gi, c;
    eg = '0; gi = -1;
    erv = (m_pend >= 0) ? 2'(1 << m_pend) : 2'b00;
    if (m_sweep == 0 && !clear) begin
      for (int k = 1; k <= 2; k++) begin
        c = (m_last + k) % 2;
        if (gi < 0 && req[c]) gi = c;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    chk("rnd gnt", gnt, eg);
    chk("rnd rvalid", rvalid, erv);
    if (m_pend >= 0) chk("rnd rdata", rdata, m_pdata);
    chk("rnd busy", busy, (m_sweep > 0));
    chk("rnd clear_done", clear_done, (m_sweep == 1));
    m_pend = -1;
    if (m_sweep > 0) m_sweep--;
    else if (clear) begin
      m_sweep = DEPTH;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (gi >= 0) begin
      m_last = gi;
      if (we[gi]) m_mem[addr[gi*6 +: 6]] = wdata[gi*8 +: 8];
      else begin
        m_pend  = gi;
        m_pdata = m_mem[addr[gi*6 +: 6]];
      end
    end
    prev_gnt = eg;
  endtask

  initial begin
    logic [3:0]  eg4 [5];
    logic [3:0]  erv4 [5];
    logic [15:0] erd4 [5];

    tbl[0]  = '{2'b01, 2'b00, 6'h2A, 6'h00, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00};
    tbl[1]  = '{2'b00, 2'b00, 6'h2A, 6'h00, 8'h00, 8'h00, 2'b00, 2'b01, 8'h00};
    tbl[2]  = '{2'b10, 2'b10, 6'h00, 6'h11, 8'h00, 8'h5C, 2'b10, 2'b00, 8'h00};
    tbl[3]  = '{2'b01, 2'b00, 6'h11, 6'h11, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00};
    tbl[4]  = '{2'b00, 2'b00, 6'h11, 6'h11, 8'h00, 8'h00, 2'b00, 2'b01, 8'h5C};
    tbl[5]  = '{2'b10, 2'b00, 6'h11, 6'h11, 8'h00, 8'h00, 2'b10, 2'b00, 8'h00};
    tbl[6]  = '{2'b11, 2'b00, 6'h11, 6'h11, 8'h00, 8'h00, 2'b01, 2'b10, 8'h5C};
    tbl[7]  = '{2'b11, 2'b00, 6'h11, 6'h11, 8'h00, 8'h00, 2'b10, 2'b01, 8'h5C};
    tbl[8]  = '{2'b11, 2'b00, 6'h11, 6'h11, 8'h00, 8'h00, 2'b01, 2'b10, 8'h5C};
    tbl[9]  = '{2'b11, 2'b00, 6'h11, 6'h11, 8'h00, 8'h00, 2'b10, 2'b01, 8'h5C};
    tbl[10] = '{2'b00, 2'b00, 6'h11, 6'h11, 8'h00, 8'h00, 2'b00, 2'b10, 8'h5C};

    reset = 1'b1; clear = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    reset4 = 1'b1; clear4 = 1'b0; req4 = '0; we4 = '0; addr4 = '0; wdata4 = '0;

    @(negedge clk);
    chk("rst gnt", gnt, 2'b00);
    chk("rst rvalid", rvalid, 2'b00);
    chk("rst rdata", rdata, 8'h00);
    chk("rst busy", busy, 1'b1);
    chk("rst clear_done", clear_done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    req = 2'b11;
    sweep("post-reset", DEPTH);

    foreach (tbl[i]) begin
      req = tbl[i].req; we = tbl[i].we;
      addr = {tbl[i].a1, tbl[i].a0}; wdata = {tbl[i].d1, tbl[i].d0};
      @(negedge clk);
      chk($sformatf("vec%0d gnt", i), gnt, tbl[i].egnt);
      chk($sformatf("vec%0d rvalid", i), rvalid, tbl[i].ervalid);
      if (tbl[i].ervalid != 2'b00) chk($sformatf("vec%0d rdata", i), rdata, tbl[i].erdata);
      chk($sformatf("vec%0d busy", i), busy, 1'b0);
      @(posedge clk); #1;
    end

    // clear beats a same-cycle ch0 request; the request is served after the sweep
    req = 2'b01; we = 2'b00; addr = {6'h11, 6'h11}; clear = 1'b1;
    @(negedge clk);
    chk("clr gnt", gnt, 2'b00);
    chk("clr busy before", busy, 1'b0);
    @(posedge clk); #1;
    clear = 1'b0;
    sweep("clear1", DEPTH);
    @(negedge clk);
    chk("post-clr gnt", gnt, 2'b01);
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    chk("post-clr rvalid", rvalid, 2'b01);
    chk("post-clr rdata", rdata, 8'h00);
    @(posedge clk); #1;

    // read granted just before clear returns pre-clear data
    req = 2'b01; we = 2'b01; addr = {6'h11, 6'h11}; wdata = {8'h00, 8'hA7};
    @(negedge clk);
    chk("wr A7 gnt", gnt, 2'b01);
    @(posedge clk); #1;
    req = 2'b10; we = 2'b00;
    @(negedge clk);
    chk("rd1 gnt", gnt, 2'b10);
    @(posedge clk); #1;
    req = 2'b00; clear = 1'b1;
    @(negedge clk);
    chk("pre-clr rvalid", rvalid, 2'b10);
    chk("pre-clr rdata", rdata, 8'hA7);
    chk("pre-clr gnt", gnt, 2'b00);
    @(posedge clk); #1;
    clear = 1'b0;
    sweep("clear2", DEPTH);

    // reset drops a pending rvalid and restarts the sweep
    req = 2'b01; we = 2'b00;
    @(negedge clk);
    chk("rst-rd gnt", gnt, 2'b01);
    @(posedge clk); #1;
    req = 2'b00;
    chk("rst-rd rvalid before", rvalid, 2'b01);
    reset = 1'b1;
    #1;
    chk("rst-rd rvalid after", rvalid, 2'b00);
    chk("rst-rd rdata after", rdata, 8'h00);
    chk("rst-rd busy", busy, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    sweep("sweep-part", 30);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sweep("sweep-restart", DEPTH);

    // random traffic against the model
    m_sweep = 0; m_last = 1; m_pend = -1; m_pdata = '0; prev_gnt = '0;
    foreach (m_mem[i]) m_mem[i] = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (req[i] && !prev_gnt[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else begin
          req[i] = ($urandom_range(0, 2) != 0);
          we[i] = 1'($urandom_range(0, 1));
          addr[i*6 +: 6] = 6'($urandom_range(0, 7));
          wdata[i*8 +: 8] = 8'($urandom);
        end
      end
      clear = ($urandom_range(0, 149) == 0);
      @(negedge clk);
      model_step();
      @(posedge clk); #1;
    end
    clear = 1'b0; req = '0;

    // 4-channel, 16-bit, 16-deep instance
    reset4 = 1'b0;
    req4 = 4'b1111;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      chk("ch4 sweep busy", busy4, 1'b1);
      chk("ch4 sweep gnt", gnt4, 4'b0000);
      chk("ch4 sweep clear_done", cd4, (n == 16));
      @(posedge clk); #1;
    end
    eg4  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    erv4 = '{4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b1000};
    erd4 = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF};
    we4 = 4'b0100; addr4 = {4{4'h7}}; wdata4 = '0; wdata4[32 +: 16] = 16'hBEEF;
    for (int c = 0; c < 5; c++) begin
      req4 = (c < 4) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      chk($sformatf("ch4 c%0d gnt", c), gnt4, eg4[c]);
      chk($sformatf("ch4 c%0d rvalid", c), rvalid4, erv4[c]);
      if (erv4[c] != 4'b0000) chk($sformatf("ch4 c%0d rdata", c), rdata4, erd4[c]);
      chk($sformatf("ch4 c%0d busy", c), busy4, 1'b0);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
